// File: rtl/rvfi_commit_packer.sv
// rvfi_commit_packer: gathers per-instruction commit fields from an
// out-of-order core, keyed by ROB index, and emits one registered in-order
// RVFI packet per retired instruction.
// Optional feature macro: RVFI_HALT_DETECT_EN (sticky halt on a self-loop,
// after which no further packets are emitted).
module rvfi_commit_packer #(
    parameter int ROB_DEPTH = 16,
    parameter int ROB_IDX_W = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 disp_valid,
    input  logic [ROB_IDX_W-1:0] disp_idx,
    input  logic [31:0]          disp_pc,
    input  logic [31:0]          disp_inst,
    input  logic [4:0]           disp_rs1,
    input  logic [4:0]           disp_rs2,
    input  logic [4:0]           disp_rd,
    input  logic                 opnd_valid,
    input  logic [ROB_IDX_W-1:0] opnd_idx,
    input  logic [31:0]          opnd_rs1_rdata,
    input  logic [31:0]          opnd_rs2_rdata,
    input  logic                 wb_valid,
    input  logic [ROB_IDX_W-1:0] wb_idx,
    input  logic [31:0]          wb_rd_wdata,
    input  logic [31:0]          wb_pc_wdata,
    input  logic                 mem_valid,
    input  logic [ROB_IDX_W-1:0] mem_idx,
    input  logic [31:0]          mem_addr,
    input  logic [3:0]           mem_rmask,
    input  logic [3:0]           mem_wmask,
    input  logic [31:0]          mem_rdata,
    input  logic [31:0]          mem_wdata,
    input  logic                 ret_valid,
    input  logic [ROB_IDX_W-1:0] ret_idx,
    input  logic                 flush,
    output logic                 rvfi_valid,
    output logic [63:0]          rvfi_order,
    output logic [31:0]          rvfi_inst,
    output logic [31:0]          rvfi_pc_rdata,
    output logic [31:0]          rvfi_pc_wdata,
    output logic [31:0]          rvfi_rs1_rdata,
    output logic [31:0]          rvfi_rs2_rdata,
    output logic [31:0]          rvfi_rd_wdata,
    output logic [31:0]          rvfi_mem_addr,
    output logic [31:0]          rvfi_mem_rdata,
    output logic [31:0]          rvfi_mem_wdata,
    output logic [4:0]           rvfi_rs1_addr,
    output logic [4:0]           rvfi_rs2_addr,
    output logic [4:0]           rvfi_rd_addr,
    output logic [3:0]           rvfi_mem_rmask,
    output logic [3:0]           rvfi_mem_wmask,
    output logic                 rvfi_halt,
    output logic                 proto_err
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } entry_t;

    entry_t               ent_q [ROB_DEPTH];
    entry_t               ent_d [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] alloc_q, alloc_d;
    logic [ROB_DEPTH-1:0] opnd_q, opnd_d;
    logic [ROB_DEPTH-1:0] wb_q, wb_d;
    logic [ROB_DEPTH-1:0] mem_q, mem_d;

    entry_t      ret_e_s;
    logic        ret_mem_s;
    logic        emit_s;
    logic        err_s;
    logic        halt_d;
    logic [63:0] cnt_q;

    logic        valid_q;
    logic [63:0] order_q;
    logic [31:0] inst_q, pc_rdata_q, pc_wdata_q, rs1_rdata_q, rs2_rdata_q, rd_wdata_q;
    logic [31:0] mem_addr_q, mem_rdata_q, mem_wdata_q;
    logic [4:0]  rs1_addr_q, rs2_addr_q, rd_addr_q;
    logic [3:0]  mem_rmask_q, mem_wmask_q;
    logic        halt_q;
    logic        proto_err_q;

    // Per-entry next state: release on retire/flush, late-phase updates, then dispatch overrides all.
    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            ent_d[i]   = ent_q[i];
            alloc_d[i] = alloc_q[i];
            opnd_d[i]  = opnd_q[i];
            wb_d[i]    = wb_q[i];
            mem_d[i]   = mem_q[i];
            if (flush || (ret_valid && (ret_idx == ROB_IDX_W'(i)))) begin
                alloc_d[i] = 1'b0;
            end else begin
                alloc_d[i] = alloc_q[i];
            end
            if (opnd_valid && (opnd_idx == ROB_IDX_W'(i))) begin
                ent_d[i].rs1_rdata = (ent_q[i].rs1 == 5'd0) ? 32'd0 : opnd_rs1_rdata;
                ent_d[i].rs2_rdata = (ent_q[i].rs2 == 5'd0) ? 32'd0 : opnd_rs2_rdata;
                opnd_d[i]          = 1'b1;
            end else begin
                opnd_d[i] = opnd_q[i];
            end
            if (wb_valid && (wb_idx == ROB_IDX_W'(i))) begin
                ent_d[i].rd_wdata = wb_rd_wdata;
                ent_d[i].pc_wdata = wb_pc_wdata;
                wb_d[i]           = 1'b1;
            end else begin
                wb_d[i] = wb_q[i];
            end
            if (mem_valid && (mem_idx == ROB_IDX_W'(i))) begin
                ent_d[i].mem_addr  = mem_addr;
                ent_d[i].mem_rmask = mem_rmask;
                ent_d[i].mem_wmask = mem_wmask;
                ent_d[i].mem_rdata = mem_rdata;
                ent_d[i].mem_wdata = mem_wdata;
                mem_d[i]           = 1'b1;
            end else begin
                mem_d[i] = mem_q[i];
            end
            // Dispatch is last so it wins over same-cycle late events and over flush.
            if (disp_valid && (disp_idx == ROB_IDX_W'(i))) begin
                ent_d[i]      = '0;
                ent_d[i].pc   = disp_pc;
                ent_d[i].inst = disp_inst;
                ent_d[i].rs1  = disp_rs1;
                ent_d[i].rs2  = disp_rs2;
                ent_d[i].rd   = disp_rd;
                alloc_d[i]    = 1'b1;
                opnd_d[i]     = 1'b0;
                wb_d[i]       = 1'b0;
                mem_d[i]      = 1'b0;
            end else begin
                alloc_d[i] = alloc_d[i];
            end
        end
    end

    // Entry storage and phase bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            alloc_q <= '0;
            opnd_q  <= '0;
            wb_q    <= '0;
            mem_q   <= '0;
        end else begin
            ent_q   <= ent_d;
            alloc_q <= alloc_d;
            opnd_q  <= opnd_d;
            wb_q    <= wb_d;
            mem_q   <= mem_d;
        end
    end

    // Protocol checks on the current cycle's requests against the stored phase bits.
    always_comb begin
        err_s = 1'b0;
        if (ret_valid && (!alloc_q[ret_idx] || !wb_q[ret_idx])) begin
            err_s = 1'b1;
        end else if (opnd_valid && !alloc_q[opnd_idx]) begin
            err_s = 1'b1;
        end else if (wb_valid && !alloc_q[wb_idx]) begin
            err_s = 1'b1;
        end else if (mem_valid && !alloc_q[mem_idx]) begin
            err_s = 1'b1;
        end else if (disp_valid && alloc_q[disp_idx] &&
                     !(ret_valid && (ret_idx == disp_idx))) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Halt detection looks at the packet currently on the outputs.
    always_comb begin
`ifdef RVFI_HALT_DETECT_EN
        if (halt_q) begin
            halt_d = 1'b1;
        end else if (valid_q && ((pc_rdata_q == pc_wdata_q) ||
                                 (inst_q == 32'h0000_0063) ||
                                 (inst_q == 32'h0000_006f))) begin
            halt_d = 1'b1;
        end else begin
            halt_d = 1'b0;
        end
`else
        halt_d = 1'b0;
`endif
    end

    // Retiring entry lookup; nothing is emitted once halt is (being) set.
    always_comb begin
        ret_e_s   = ent_q[ret_idx];
        ret_mem_s = mem_q[ret_idx];
        if (ret_valid && !halt_d) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end
    end

    // Registered packet outputs, order counter and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            cnt_q       <= 64'd0;
            order_q     <= 64'd0;
            inst_q      <= 32'd0;
            pc_rdata_q  <= 32'd0;
            pc_wdata_q  <= 32'd0;
            rs1_rdata_q <= 32'd0;
            rs2_rdata_q <= 32'd0;
            rd_wdata_q  <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
            mem_wdata_q <= 32'd0;
            rs1_addr_q  <= 5'd0;
            rs2_addr_q  <= 5'd0;
            rd_addr_q   <= 5'd0;
            mem_rmask_q <= 4'd0;
            mem_wmask_q <= 4'd0;
            halt_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            valid_q     <= emit_s;
            halt_q      <= halt_d;
            proto_err_q <= proto_err_q | err_s;
            if (emit_s) begin
                cnt_q       <= cnt_q + 64'd1;
                order_q     <= cnt_q;
                inst_q      <= ret_e_s.inst;
                pc_rdata_q  <= ret_e_s.pc;
                pc_wdata_q  <= ret_e_s.pc_wdata;
                rs1_addr_q  <= ret_e_s.rs1;
                rs2_addr_q  <= ret_e_s.rs2;
                rd_addr_q   <= ret_e_s.rd;
                rs1_rdata_q <= (ret_e_s.rs1 == 5'd0) ? 32'd0 : ret_e_s.rs1_rdata;
                rs2_rdata_q <= (ret_e_s.rs2 == 5'd0) ? 32'd0 : ret_e_s.rs2_rdata;
                rd_wdata_q  <= (ret_e_s.rd == 5'd0) ? 32'd0 : ret_e_s.rd_wdata;
                mem_addr_q  <= ret_mem_s ? ret_e_s.mem_addr  : 32'd0;
                mem_rmask_q <= ret_mem_s ? ret_e_s.mem_rmask : 4'd0;
                mem_wmask_q <= ret_mem_s ? ret_e_s.mem_wmask : 4'd0;
                mem_rdata_q <= ret_mem_s ? ret_e_s.mem_rdata : 32'd0;
                mem_wdata_q <= ret_mem_s ? ret_e_s.mem_wdata : 32'd0;
            end
        end
    end

    assign rvfi_valid     = valid_q;
    assign rvfi_order     = order_q;
    assign rvfi_inst      = inst_q;
    assign rvfi_pc_rdata  = pc_rdata_q;
    assign rvfi_pc_wdata  = pc_wdata_q;
    assign rvfi_rs1_rdata = rs1_rdata_q;
    assign rvfi_rs2_rdata = rs2_rdata_q;
    assign rvfi_rd_wdata  = rd_wdata_q;
    assign rvfi_mem_addr  = mem_addr_q;
    assign rvfi_mem_rdata = mem_rdata_q;
    assign rvfi_mem_wdata = mem_wdata_q;
    assign rvfi_rs1_addr  = rs1_addr_q;
    assign rvfi_rs2_addr  = rs2_addr_q;
    assign rvfi_rd_addr   = rd_addr_q;
    assign rvfi_mem_rmask = mem_rmask_q;
    assign rvfi_mem_wmask = mem_wmask_q;
    assign rvfi_halt      = halt_q;
    assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_rvfi_commit_packer.sv
// Testbench for rvfi_commit_packer: table-driven single-instruction vectors
// plus hand-written multi-cycle sequences; packets checked via a scoreboard.
module tb_rvfi_commit_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        disp_valid = 1'b0, opnd_valid = 1'b0, wb_valid = 1'b0, mem_valid = 1'b0;
    logic        ret_valid = 1'b0, flush = 1'b0;
    logic [3:0]  disp_idx = 4'd0, opnd_idx = 4'd0, wb_idx = 4'd0, mem_idx = 4'd0, ret_idx = 4'd0;
    logic [31:0] disp_pc = 32'd0, disp_inst = 32'd0;
    logic [4:0]  disp_rs1 = 5'd0, disp_rs2 = 5'd0, disp_rd = 5'd0;
    logic [31:0] opnd_rs1_rdata = 32'd0, opnd_rs2_rdata = 32'd0;
    logic [31:0] wb_rd_wdata = 32'd0, wb_pc_wdata = 32'd0;
    logic [31:0] mem_addr = 32'd0, mem_rdata = 32'd0, mem_wdata = 32'd0;
    logic [3:0]  mem_rmask = 4'd0, mem_wmask = 4'd0;

    logic        rvfi_valid, rvfi_halt, proto_err;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata;
    logic [31:0] rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

    rvfi_commit_packer #(.ROB_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_idx(disp_idx), .disp_pc(disp_pc), .disp_inst(disp_inst),
        .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rd(disp_rd),
        .opnd_valid(opnd_valid), .opnd_idx(opnd_idx),
        .opnd_rs1_rdata(opnd_rs1_rdata), .opnd_rs2_rdata(opnd_rs2_rdata),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_rd_wdata(wb_rd_wdata), .wb_pc_wdata(wb_pc_wdata),
        .mem_valid(mem_valid), .mem_idx(mem_idx), .mem_addr(mem_addr), .mem_rmask(mem_rmask),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .ret_valid(ret_valid), .ret_idx(ret_idx), .flush(flush),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_inst(rvfi_inst),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_halt(rvfi_halt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] inst, pc, pcw, r1d, r2d, rdw, addr, mrd, mwd;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  rm, wm;
    } pkt_t;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] pc, inst;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] r1d, r2d, rdw, pcw;
        logic        has_mem;
        logic [31:0] addr;
        logic [3:0]  rm, wm;
        logic [31:0] mrd, mwd;
        logic [31:0] e_r1d, e_r2d, e_rdw, e_addr;
        logic [3:0]  e_rm, e_wm;
        logic [31:0] e_mrd, e_mwd;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    pkt_t        sb[$];
    pkt_t        mon_p;
    logic [63:0] exp_order = 64'd0;
    vec_t        vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every pulse must match the oldest expected packet.
    always @(negedge clk) begin
        if (rvfi_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got packet order %0d, required no packet", rvfi_order);
            end else begin
                mon_p = sb.pop_front();
                chk("order", rvfi_order, mon_p.order);
                chk("inst", rvfi_inst, mon_p.inst);
                chk("pc_rdata", rvfi_pc_rdata, mon_p.pc);
                chk("pc_wdata", rvfi_pc_wdata, mon_p.pcw);
                chk("rs1_addr", rvfi_rs1_addr, mon_p.rs1);
                chk("rs2_addr", rvfi_rs2_addr, mon_p.rs2);
                chk("rd_addr", rvfi_rd_addr, mon_p.rd);
                chk("rs1_rdata", rvfi_rs1_rdata, mon_p.r1d);
                chk("rs2_rdata", rvfi_rs2_rdata, mon_p.r2d);
                chk("rd_wdata", rvfi_rd_wdata, mon_p.rdw);
                chk("mem_addr", rvfi_mem_addr, mon_p.addr);
                chk("mem_rmask", rvfi_mem_rmask, mon_p.rm);
                chk("mem_wmask", rvfi_mem_wmask, mon_p.wm);
                chk("mem_rdata", rvfi_mem_rdata, mon_p.mrd);
                chk("mem_wdata", rvfi_mem_wdata, mon_p.mwd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        disp_valid = 1'b0; opnd_valid = 1'b0; wb_valid = 1'b0;
        mem_valid = 1'b0; ret_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic set_disp(input logic [3:0] idx, input logic [31:0] pc, input logic [31:0] inst,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        disp_valid = 1'b1; disp_idx = idx; disp_pc = pc; disp_inst = inst;
        disp_rs1 = rs1; disp_rs2 = rs2; disp_rd = rd;
    endtask

    task automatic set_opnd(input logic [3:0] idx, input logic [31:0] d1, input logic [31:0] d2);
        opnd_valid = 1'b1; opnd_idx = idx; opnd_rs1_rdata = d1; opnd_rs2_rdata = d2;
    endtask

    task automatic set_wb(input logic [3:0] idx, input logic [31:0] rdw, input logic [31:0] pcw);
        wb_valid = 1'b1; wb_idx = idx; wb_rd_wdata = rdw; wb_pc_wdata = pcw;
    endtask

    task automatic set_mem(input logic [3:0] idx, input logic [31:0] a, input logic [3:0] rm,
                           input logic [3:0] wm, input logic [31:0] rd, input logic [31:0] wd);
        mem_valid = 1'b1; mem_idx = idx; mem_addr = a; mem_rmask = rm;
        mem_wmask = wm; mem_rdata = rd; mem_wdata = wd;
    endtask

    task automatic set_ret(input logic [3:0] idx, input pkt_t p);
        p.order = exp_order;
        exp_order = exp_order + 64'd1;
        sb.push_back(p);
        ret_valid = 1'b1;
        ret_idx = idx;
    endtask

    function automatic pkt_t mkp(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] pcw,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] r1d, input logic [31:0] r2d, input logic [31:0] rdw,
                                 input logic [31:0] addr, input logic [3:0] rm, input logic [3:0] wm,
                                 input logic [31:0] mrd, input logic [31:0] mwd);
        pkt_t p;
        p = '0;
        p.inst = inst; p.pc = pc; p.pcw = pcw; p.rs1 = rs1; p.rs2 = rs2; p.rd = rd;
        p.r1d = r1d; p.r2d = r2d; p.rdw = rdw; p.addr = addr; p.rm = rm; p.wm = wm;
        p.mrd = mrd; p.mwd = mwd;
        return p;
    endfunction

    initial begin
        vec_t        v;
        logic [3:0]  ii;
        logic [31:0] pc_v;

        // idx, pc, inst, rs1, rs2, rd, r1d, r2d, rdw, pcw, has_mem, addr, rm, wm, mrd, mwd,
        // expected: r1d, r2d, rdw, addr, rm, wm, mrd, mwd
        vecs[0] = '{4'd3, 32'h1000, 32'h00500093, 5'd0, 5'd0, 5'd1, 32'hAAAA, 32'hBBBB, 32'h5, 32'h1004,
                    1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'h5, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0};
        vecs[1] = '{4'd7, 32'h1004, 32'h00f12123, 5'd2, 5'd15, 5'd0, 32'h2000, 32'hBEEF0000, 32'h1234, 32'h1008,
                    1'b1, 32'h2002, 4'h0, 4'hC, 32'h0, 32'hBEEF0000,
                    32'h2000, 32'hBEEF0000, 32'h0, 32'h2002, 4'h0, 4'hC, 32'h0, 32'hBEEF0000};
        vecs[2] = '{4'd0, 32'h1008, 32'h0005a503, 5'd11, 5'd0, 5'd10, 32'h3000, 32'h1111, 32'hCAFE, 32'h100C,
                    1'b1, 32'h3004, 4'hF, 4'h0, 32'hCAFE, 32'h0,
                    32'h3000, 32'h0, 32'hCAFE, 32'h3004, 4'hF, 4'h0, 32'hCAFE, 32'h0};
        vecs[3] = '{4'd15, 32'h100C, 32'h01df0fb3, 5'd30, 5'd29, 5'd31, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h1010,
                    1'b0, 32'h9999, 4'hF, 4'hF, 32'h1, 32'h2,
                    32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0};
        vecs[4] = '{4'd5, 32'h1010, 32'h008000ef, 5'd0, 5'd0, 5'd1, 32'h5, 32'h6, 32'h1014, 32'h1018,
                    1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0,
                    32'h0, 32'h0, 32'h1014, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0};

        // Reset state.
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", rvfi_valid, 64'd0);
        chk("rst_order", rvfi_order, 64'd0);
        chk("rst_halt", rvfi_halt, 64'd0);
        chk("rst_proto_err", proto_err, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Table-driven single-instruction lifecycles.
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            set_disp(v.idx, v.pc, v.inst, v.rs1, v.rs2, v.rd); tick();
            set_opnd(v.idx, v.r1d, v.r2d); tick();
            set_wb(v.idx, v.rdw, v.pcw); tick();
            if (v.has_mem) begin
                set_mem(v.idx, v.addr, v.rm, v.wm, v.mrd, v.mwd); tick();
            end
            set_ret(v.idx, mkp(v.inst, v.pc, v.pcw, v.rs1, v.rs2, v.rd, v.e_r1d, v.e_r2d, v.e_rdw,
                               v.e_addr, v.e_rm, v.e_wm, v.e_mrd, v.e_mwd));
            tick();
            tick();
            chk("pulse_width", rvfi_valid, 64'd0);
        end

        // Back-to-back retires of idx0..3; last retire shares a cycle with a new dispatch to idx3.
        for (int i = 0; i < 4; i++) begin
            ii = 4'(i);
            pc_v = 32'h2000 + 32'(4 * i);
            set_disp(ii, pc_v, 32'h00100113, 5'd0, 5'd0, 5'd2); tick();
            set_wb(ii, 32'h100 + 32'(i), pc_v + 32'd4); tick();
        end
        for (int i = 0; i < 4; i++) begin
            ii = 4'(i);
            pc_v = 32'h2000 + 32'(4 * i);
            set_ret(ii, mkp(32'h00100113, pc_v, pc_v + 32'd4, 5'd0, 5'd0, 5'd2, 32'd0, 32'd0,
                            32'h100 + 32'(i), 32'd0, 4'd0, 4'd0, 32'd0, 32'd0));
            if (i == 3) set_disp(4'd3, 32'h3000, 32'h00700193, 5'd0, 5'd0, 5'd3);
            tick();
        end
        set_wb(4'd3, 32'h77, 32'h3004); tick();
        set_ret(4'd3, mkp(32'h00700193, 32'h3000, 32'h3004, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0,
                          32'h77, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0));
        tick();
        chk("proto_err_clean_a", proto_err, 64'd0);

        // Flush together with dispatch: the dispatch survives.
        set_disp(4'd9, 32'h4000, 32'h04400213, 5'd0, 5'd0, 5'd4); flush = 1'b1; tick();
        set_wb(4'd9, 32'h44, 32'h4004); tick();
        set_ret(4'd9, mkp(32'h04400213, 32'h4000, 32'h4004, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0,
                          32'h44, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0));
        tick();
        chk("proto_err_clean_c", proto_err, 64'd0);

        // Flush with retire of idx5, then retire of flushed idx6.
        set_disp(4'd5, 32'h5000, 32'h00a00213, 5'd0, 5'd0, 5'd4); tick();
        set_disp(4'd6, 32'h5004, 32'h00b00293, 5'd0, 5'd0, 5'd5); tick();
        set_wb(4'd5, 32'hA, 32'h5004); tick();
        set_wb(4'd6, 32'hB, 32'h5008); tick();
        set_ret(4'd5, mkp(32'h00a00213, 32'h5000, 32'h5004, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0,
                          32'hA, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0));
        flush = 1'b1;
        tick();
        chk("proto_err_flush_ret", proto_err, 64'd0);
        set_ret(4'd6, mkp(32'h00b00293, 32'h5004, 32'h5008, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0,
                          32'hB, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0));
        tick();
        chk("proto_err_set", proto_err, 64'd1);

        // Reset with 8 entries allocated.
        for (int i = 8; i < 16; i++) begin
            set_disp(4'(i), 32'h6000 + 32'(4 * (i - 8)), 32'h00000013, 5'd0, 5'd0, 5'd0);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rvfi_valid, 64'd0);
        chk("mid_rst_order", rvfi_order, 64'd0);
        chk("mid_rst_inst", rvfi_inst, 64'd0);
        chk("mid_rst_pc", rvfi_pc_rdata, 64'd0);
        chk("mid_rst_rd_wdata", rvfi_rd_wdata, 64'd0);
        chk("mid_rst_proto_err", proto_err, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        sb.delete();
        exp_order = 64'd0;
        set_disp(4'd8, 32'h7000, 32'h00100093, 5'd0, 5'd0, 5'd1); tick();
        set_wb(4'd8, 32'h1, 32'h7004); tick();
        set_ret(4'd8, mkp(32'h00100093, 32'h7000, 32'h7004, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0,
                          32'h1, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0));
        tick();
        tick();
        chk("post_rst_proto_err", proto_err, 64'd0);

        // Self-loop jump: halt behaviour depends on the build.
        set_disp(4'd1, 32'h40, 32'h0000006f, 5'd0, 5'd0, 5'd0); tick();
        set_wb(4'd1, 32'h0, 32'h40); tick();
        set_ret(4'd1, mkp(32'h0000006f, 32'h40, 32'h40, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0,
                          32'd0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0));
        tick();
        tick();
`ifdef RVFI_HALT_DETECT_EN
        chk("halt_set", rvfi_halt, 64'd1);
`else
        chk("halt_off", rvfi_halt, 64'd0);
`endif
        set_disp(4'd2, 32'h44, 32'h00000013, 5'd0, 5'd0, 5'd0); tick();
        set_wb(4'd2, 32'h0, 32'h48); tick();
`ifdef RVFI_HALT_DETECT_EN
        ret_valid = 1'b1;
        ret_idx = 4'd2;
`else
        set_ret(4'd2, mkp(32'h00000013, 32'h44, 32'h48, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0,
                          32'd0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0));
`endif
        tick();
        tick();
`ifdef RVFI_HALT_DETECT_EN
        chk("halt_sticky", rvfi_halt, 64'd1);
`else
        chk("halt_still_off", rvfi_halt, 64'd0);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
